tdm_demux: RTL and testbench

- Time-division demultiplexer: the receive end of a TDM link whose transmit end interleaves NCH channels through a multiplexer onto one word-wide stream.
- Hunts for frame sync and tracks the slot index.
- Steers each valid word into its channel's output register and pulses that channel's valid strobe.
- Flags frame completion and sync errors.
- Sits between the serial link front end and the per-channel consumers.

---
 rtl/tdm_demux_pkg.sv | 17 +
 rtl/tdm_demux_if.sv | 26 ++
 rtl/tdm_demux_slot_reg.sv | 35 +++
 rtl/tdm_demux.sv | 95 +++++++++
 tb/tb_tdm_demux.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer: frame-tracking states,
// default geometry and the slot-counter width helper.
package tdm_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int slot_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// TDM link word stream in, per-channel registers and status strobes out.
interface tdm_demux_if import tdm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
);

  logic [W-1:0]     din;
  logic             din_valid;
  logic             frame_sync;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux_slot_reg.sv
// One channel output register: loads a word when selected and raises a
// single-cycle valid strobe in the cycle the new word becomes visible.
module demux_slot_reg import tdm_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = load ? d : data_q;
    valid_d = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/tdm_demux.sv
// Receive side of a TDM link: hunts for frame sync, tracks the slot index and
// steers each accepted word into its channel register, flagging framing errors.
module tdm_demux import tdm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int            SB   = slot_bits(NCH);
  localparam logic [SB-1:0] LAST = SB'(NCH - 1);
  localparam logic [SB-1:0] ONE  = SB'(1);

  state_e           state_q, state_d;
  logic [SB-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic             locked_q, locked_d;
  logic             load_en;
  logic [SB-1:0]    load_slot;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;

  // A sync word always restarts the frame at slot 0, even mid-frame; only a
  // missing sync at a frame boundary drops lock.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    load_en      = 1'b0;
    load_slot    = cnt_q;

    if (bus.din_valid) begin
      if (bus.frame_sync) begin
        load_en    = 1'b1;
        load_slot  = '0;
        cnt_d      = ONE;
        state_d    = LOCKED;
        sync_err_d = (state_q == LOCKED) && (cnt_q != '0);
      end else if (state_q == LOCKED) begin
        if (cnt_q == '0) begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
        end else begin
          load_en = 1'b1;
          if (cnt_q == LAST) begin
            frame_done_d = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= locked_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot_reg #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_en && (load_slot == SB'(k))),
      .d     (bus.din),
      .q     (ch_data[k*W +: W]),
      .valid (ch_valid[k])
    );
  end

  assign bus.ch_data    = ch_data;
  assign bus.ch_valid   = ch_valid;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, W=8): per-scenario tasks with
// hand-computed flag vectors {ch_valid, frame_done, locked, sync_err}.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [6:0] flags();
    return {bus.ch_valid, bus.frame_done, bus.locked, bus.sync_err};
  endfunction

  // Word is presented at the falling edge and observed 1ns after the next rising edge.
  task automatic apply_word(input logic [7:0] d, input logic v, input logic s);
    @(negedge clk);
    bus.din        = d;
    bus.din_valid  = v;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.din        = 8'h5A;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({flags(), bus.ch_data} !== {7'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_hold got flags=%b data=%h exp flags=0000000 data=00000000", flags(), bus.ch_data);
    end
    rst_n = 1'b1;
    repeat (2) begin
      apply_word(8'h5A, 1'b0, 1'b0);
      checks++;
      if ({flags(), bus.ch_data} !== {7'b0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_idle got flags=%b data=%h exp flags=0000000 data=00000000", flags(), bus.ch_data);
      end
    end
  endtask

  task automatic test_lock_frame();
    logic [7:0] dat [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    logic       vld [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0] exp [5] = '{7'b0001_010, 7'b0010_010, 7'b0100_010, 7'b1000_110, 7'b0000_010};
    for (int i = 0; i < 5; i++) begin
      apply_word(dat[i], vld[i], i == 0);
      checks++;
      if (flags() !== exp[i]) begin
        errors++;
        $display("[TB] FAIL lock_frame step %0d got %b exp %b", i, flags(), exp[i]);
      end
    end
    checks++;
    if (bus.ch_data !== 32'hA3A2A1A0) begin
      errors++;
      $display("[TB] FAIL lock_frame_data got %h exp A3A2A1A0", bus.ch_data);
    end
  endtask

  task automatic test_hunt_discard();
    logic [7:0] dat [6] = '{8'h11, 8'h22, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic       syn [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0] exp [6] = '{7'b0000_000, 7'b0000_000, 7'b0001_010,
                            7'b0010_010, 7'b0100_010, 7'b1000_110};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_word(dat[i], 1'b1, syn[i]);
      checks++;
      if (flags() !== exp[i]) begin
        errors++;
        $display("[TB] FAIL hunt_discard step %0d got %b exp %b", i, flags(), exp[i]);
      end
    end
    checks++;
    if (bus.ch_data !== 32'hB3B2B1B0) begin
      errors++;
      $display("[TB] FAIL hunt_discard_data got %h exp B3B2B1B0", bus.ch_data);
    end
  endtask

  task automatic test_early_sync();
    logic [7:0]  dat [6] = '{8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
    logic        syn [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0]  exp [6] = '{7'b0001_010, 7'b0010_010, 7'b0001_011,
                             7'b0010_010, 7'b0100_010, 7'b1000_110};
    logic [31:0] dex [6] = '{32'hB3B2B1C0, 32'hB3B2C1C0, 32'hB3B2C1D0,
                             32'hB3B2D1D0, 32'hB3D2D1D0, 32'hD3D2D1D0};
    for (int i = 0; i < 6; i++) begin
      apply_word(dat[i], 1'b1, syn[i]);
      checks++;
      if ({flags(), bus.ch_data} !== {exp[i], dex[i]}) begin
        errors++;
        $display("[TB] FAIL early_sync step %0d got flags=%b data=%h exp flags=%b data=%h",
                 i, flags(), bus.ch_data, exp[i], dex[i]);
      end
    end
  endtask

  task automatic test_missing_sync();
    logic [7:0]  dat [9] = '{8'hE0, 8'h00, 8'hE1, 8'h00, 8'hE2, 8'h00, 8'hE3, 8'hEE, 8'h00};
    logic        vld [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [6:0]  exp [9] = '{7'b0001_010, 7'b0000_010, 7'b0010_010, 7'b0000_010,
                             7'b0100_010, 7'b0000_010, 7'b1000_110, 7'b0000_001,
                             7'b0000_000};
    logic [31:0] dex [9] = '{32'hD3D2D1E0, 32'hD3D2D1E0, 32'hD3D2E1E0, 32'hD3D2E1E0,
                             32'hD3E2E1E0, 32'hD3E2E1E0, 32'hE3E2E1E0, 32'hE3E2E1E0,
                             32'hE3E2E1E0};
    for (int i = 0; i < 9; i++) begin
      apply_word(dat[i], vld[i], i == 0);
      checks++;
      if ({flags(), bus.ch_data} !== {exp[i], dex[i]}) begin
        errors++;
        $display("[TB] FAIL missing_sync step %0d got flags=%b data=%h exp flags=%b data=%h",
                 i, flags(), bus.ch_data, exp[i], dex[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_word(8'hF0, 1'b1, 1'b1);
    apply_word(8'hF1, 1'b1, 1'b0);
    checks++;
    if (flags() !== 7'b0010_010) begin
      errors++;
      $display("[TB] FAIL async_pre got %b exp 0010010", flags());
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({flags(), bus.ch_data} !== {7'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL async_clear got flags=%b data=%h exp flags=0000000 data=00000000", flags(), bus.ch_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_word(8'hF2, 1'b1, 1'b0);
    checks++;
    if ({flags(), bus.ch_data} !== {7'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL async_relock got flags=%b data=%h exp flags=0000000 data=00000000", flags(), bus.ch_data);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_lock_frame();
    test_hunt_discard();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
